// File: rtl/capture_ctrl.sv
// ---------------------------------------------------------------------------
// capture_ctrl
//
// Sample-capture controller for the oscilloscope datapath. It takes the
// capture settings from the MCU register file and does four things:
//   - decimates the ADC streams,
//   - runs a hysteresis trigger on one selected channel,
//   - writes {ADC_B, ADC_A} pairs into external SRAM as a ring buffer,
//   - stops after WIN_DATA post-trigger samples.
//
// Build option:
//   CAPTURE_SLOPE_EN  adds the Trig_Slope input and a falling-edge trigger.
//                     Without it the trigger only fires on a rising edge.
//
// Ports:
//   CLK                 sample clock; all logic runs on the rising edge
//   nRESET              asynchronous active-low reset
//   Start_Write_s       capture run level, already synchronous to CLK
//   Enable_Trigger      1 = wait for the trigger, 0 = fire on the first ARMED store
//   Sync_channel_sel    trigger source: 0 = ADC_A, 1 = ADC_B
//   Decimation          store one sample every Decimation+1 cycles
//   Trigger_level_UP    fire threshold (arm threshold on a falling slope)
//   Trigger_level_Down  re-arm threshold (fire threshold on a falling slope)
//   WIN_DATA            number of post-trigger samples
//   ADC_A, ADC_B        channel samples, valid every cycle
//   Trig_Slope          (CAPTURE_SLOPE_EN only) 0 = rising, 1 = falling
//   SRAM_ADDR           registered write address
//   SRAM_DATA_OUT       registered write data {ADC_B, ADC_A}
//   SRAM_WE_n           active-low write strobe, one cycle wide
//   Triggered           the trigger has occurred in the current run
//   Trig_Addr           address of the trigger sample
//   Capture_Done        capture complete
// ---------------------------------------------------------------------------
module capture_ctrl #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 8
) (
  input  logic                CLK,
  input  logic                nRESET,
  input  logic                Start_Write_s,
  input  logic                Enable_Trigger,
  input  logic                Sync_channel_sel,
  input  logic [23:0]         Decimation,
  input  logic [DATA_W-1:0]   Trigger_level_UP,
  input  logic [DATA_W-1:0]   Trigger_level_Down,
  input  logic [ADDR_W-1:0]   WIN_DATA,
  input  logic [DATA_W-1:0]   ADC_A,
  input  logic [DATA_W-1:0]   ADC_B,
`ifdef CAPTURE_SLOPE_EN
  input  logic                Trig_Slope,
`endif
  output logic [ADDR_W-1:0]   SRAM_ADDR,
  output logic [2*DATA_W-1:0] SRAM_DATA_OUT,
  output logic                SRAM_WE_n,
  output logic                Triggered,
  output logic [ADDR_W-1:0]   Trig_Addr,
  output logic                Capture_Done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRETRIG,
    ST_ARMED,
    ST_POSTTRIG,
    ST_DONE
  } state_e;

  // The ring holds 2^ADDR_W samples. This is kept one bit wider so that
  // WIN_DATA = 0 gives a pre-trigger history of the full ring.
  localparam logic [ADDR_W:0] RING_SIZE = {1'b1, {ADDR_W{1'b0}}};

  state_e              state_q, state_d;
  logic                start_q;
  logic [23:0]         dec_q, dec_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     pre_q, pre_d;
  logic [ADDR_W:0]     post_q, post_d;
  logic                arm_q, arm_d;
  logic                fire_q, fire_d;
  logic                trig_q, trig_d;
  logic [ADDR_W-1:0]   trig_addr_q, trig_addr_d;
  logic                done_q, done_d;
  logic                we_n_q, we_n_d;
  logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
  logic [2*DATA_W-1:0] sram_data_q, sram_data_d;

  // These are the values the current cycle works from. In the cycle that
  // starts a run they are the entry values, so the first store at
  // address 0 happens in that same cycle and the strobe appears on the
  // next one.
  state_e              st_eff;
  logic [23:0]         dec_eff;
  logic [ADDR_W-1:0]   addr_eff;
  logic [ADDR_W:0]     pre_eff;
  logic [ADDR_W:0]     pre_next;
  logic                arm_eff;

  logic                run_start;
  logic                active;
  logic                store;
  logic [ADDR_W:0]     pre_thresh;
  logic [DATA_W-1:0]   sample;
  logic                falling;
  logic                arm_hit;
  logic                fire_hit;

  assign run_start  = (state_q == ST_IDLE) && Start_Write_s && !start_q;
  assign pre_thresh = RING_SIZE - {1'b0, WIN_DATA};
  assign sample     = Sync_channel_sel ? ADC_B : ADC_A;

`ifdef CAPTURE_SLOPE_EN
  assign falling = Trig_Slope;
`else
  assign falling = 1'b0;
`endif

  // Hysteresis: the arm condition and the fire condition are on opposite
  // thresholds. A falling slope swaps which threshold does which job.
  assign arm_hit  = falling ? (sample >= Trigger_level_UP)
                            : (sample <= Trigger_level_Down);
  assign fire_hit = falling ? (sample <= Trigger_level_Down)
                            : (sample >= Trigger_level_UP);

  // Next-state and datapath logic. The SRAM outputs are computed here and
  // registered together, so address, data and strobe change on the same
  // edge. Triggered is delayed by one extra cycle through fire_q, which
  // makes it rise on the cycle after the trigger strobe.
  always_comb begin
    st_eff   = state_q;
    dec_eff  = dec_q;
    addr_eff = addr_q;
    pre_eff  = pre_q;
    arm_eff  = arm_q;
    trig_d   = trig_q | fire_q;

    if (run_start) begin
      st_eff   = ST_PRETRIG;
      dec_eff  = '0;
      addr_eff = '0;
      pre_eff  = '0;
      arm_eff  = 1'b0;
      trig_d   = 1'b0;
    end

    state_d     = st_eff;
    dec_d       = dec_eff;
    addr_d      = addr_eff;
    pre_d       = pre_eff;
    pre_next    = pre_eff;
    post_d      = post_q;
    arm_d       = arm_eff;
    fire_d      = 1'b0;
    trig_addr_d = trig_addr_q;
    we_n_d      = 1'b1;
    sram_addr_d = sram_addr_q;
    sram_data_d = sram_data_q;
    active      = 1'b0;
    store       = 1'b0;

    if (!Start_Write_s) begin
      state_d = ST_IDLE;
    end else begin
      unique case (st_eff)
        ST_PRETRIG, ST_ARMED: active = 1'b1;
        // Uses >= rather than == so that WIN_DATA lowered mid-run below
        // the current count still ends the capture.
        ST_POSTTRIG: begin
          if (post_q >= {1'b0, WIN_DATA}) begin
            state_d = ST_DONE;
          end else begin
            active = 1'b1;
          end
        end
        default: ;
      endcase
    end

    // The decimation counter wraps at Decimation. Using >= means a
    // mid-run reduction never leaves the counter stranded above the limit.
    if (active) begin
      store = (dec_eff == 24'd0);
      if (dec_eff >= Decimation) begin
        dec_d = 24'd0;
      end else begin
        dec_d = dec_eff + 24'd1;
      end
    end

    if (store) begin
      we_n_d      = 1'b0;
      sram_addr_d = addr_eff;
      sram_data_d = {ADC_B, ADC_A};
      addr_d      = addr_eff + {{(ADDR_W-1){1'b0}}, 1'b1};
    end

    if (active) begin
      unique case (st_eff)
        ST_PRETRIG: begin
          pre_next = pre_eff + {{ADDR_W{1'b0}}, store};
          pre_d    = pre_next;
          if (store && arm_hit) begin
            arm_d = 1'b1;
          end
          if (pre_next >= pre_thresh) begin
            state_d = ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (store) begin
            if (arm_hit) begin
              arm_d = 1'b1;
            end
            // arm_eff is the flag from earlier stores. A sample that arms
            // the trigger cannot also fire it.
            if (!Enable_Trigger || (arm_eff && fire_hit)) begin
              fire_d      = 1'b1;
              trig_addr_d = addr_eff;
              post_d      = '0;
              state_d     = ST_POSTTRIG;
            end
          end
        end
        ST_POSTTRIG: begin
          if (store) begin
            post_d = post_q + {{ADDR_W{1'b0}}, 1'b1};
          end
        end
        default: ;
      endcase
    end

    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers. The reset is asynchronous, so asserting
  // nRESET mid-capture releases the write strobe at once.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q     <= ST_IDLE;
      start_q     <= 1'b0;
      dec_q       <= '0;
      addr_q      <= '0;
      pre_q       <= '0;
      post_q      <= '0;
      arm_q       <= 1'b0;
      fire_q      <= 1'b0;
      trig_q      <= 1'b0;
      trig_addr_q <= '0;
      done_q      <= 1'b0;
      we_n_q      <= 1'b1;
      sram_addr_q <= '0;
      sram_data_q <= '0;
    end else begin
      state_q     <= state_d;
      start_q     <= Start_Write_s;
      dec_q       <= dec_d;
      addr_q      <= addr_d;
      pre_q       <= pre_d;
      post_q      <= post_d;
      arm_q       <= arm_d;
      fire_q      <= fire_d;
      trig_q      <= trig_d;
      trig_addr_q <= trig_addr_d;
      done_q      <= done_d;
      we_n_q      <= we_n_d;
      sram_addr_q <= sram_addr_d;
      sram_data_q <= sram_data_d;
    end
  end

  assign SRAM_ADDR     = sram_addr_q;
  assign SRAM_DATA_OUT = sram_data_q;
  assign SRAM_WE_n     = we_n_q;
  assign Triggered     = trig_q;
  assign Trig_Addr     = trig_addr_q;
  assign Capture_Done  = done_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// ---------------------------------------------------------------------------
// tb_capture_ctrl
//
// Directed testbench for capture_ctrl with a 16-entry ring (ADDR_W = 4).
// Inputs are driven on the falling edge and outputs are sampled on the
// falling edge. Expected values are worked out by hand from the capture
// behaviour. If CAPTURE_SLOPE_EN is defined, the bench also drives
// Trig_Slope and runs a falling-slope case.
// ---------------------------------------------------------------------------
module tb_capture_ctrl;

  logic        CLK;
  logic        nRESET;
  logic        Start_Write_s;
  logic        Enable_Trigger;
  logic        Sync_channel_sel;
  logic [23:0] Decimation;
  logic [7:0]  Trigger_level_UP;
  logic [7:0]  Trigger_level_Down;
  logic [3:0]  WIN_DATA;
  logic [7:0]  ADC_A;
  logic [7:0]  ADC_B;
  logic        Trig_Slope;
  logic [3:0]  SRAM_ADDR;
  logic [15:0] SRAM_DATA_OUT;
  logic        SRAM_WE_n;
  logic        Triggered;
  logic [3:0]  Trig_Addr;
  logic        Capture_Done;

  int vectors;
  int miscompares;

  capture_ctrl #(
    .ADDR_W(4),
    .DATA_W(8)
  ) dut (
    .CLK               (CLK),
    .nRESET            (nRESET),
    .Start_Write_s     (Start_Write_s),
    .Enable_Trigger    (Enable_Trigger),
    .Sync_channel_sel  (Sync_channel_sel),
    .Decimation        (Decimation),
    .Trigger_level_UP  (Trigger_level_UP),
    .Trigger_level_Down(Trigger_level_Down),
    .WIN_DATA          (WIN_DATA),
    .ADC_A             (ADC_A),
    .ADC_B             (ADC_B),
`ifdef CAPTURE_SLOPE_EN
    .Trig_Slope        (Trig_Slope),
`endif
    .SRAM_ADDR         (SRAM_ADDR),
    .SRAM_DATA_OUT     (SRAM_DATA_OUT),
    .SRAM_WE_n         (SRAM_WE_n),
    .Triggered         (Triggered),
    .Trig_Addr         (Trig_Addr),
    .Capture_Done      (Capture_Done)
  );

  // 10-time-unit sample clock.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Drives every capture setting and both ADC channels in one call.
  task automatic applyStimulus(input logic start, input logic [23:0] dec,
                               input logic en, input logic sel,
                               input logic [3:0] win, input logic [7:0] a,
                               input logic [7:0] b);
    Start_Write_s    = start;
    Decimation       = dec;
    Enable_Trigger   = en;
    Sync_channel_sel = sel;
    WIN_DATA         = win;
    ADC_A            = a;
    ADC_B            = b;
  endtask

  // Compares one observed output with its hand-computed value and counts
  // both the comparison and any miscompare.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors            = 0;
    miscompares        = 0;
    nRESET             = 1'b0;
    Trig_Slope         = 1'b0;
    Trigger_level_UP   = 8'hC0;
    Trigger_level_Down = 8'h40;
    applyStimulus(1'b0, 24'd0, 1'b0, 1'b0, 4'd4, 8'h00, 8'h00);

    // Reset values
    repeat (2) @(negedge CLK);
    checkOutput("rst_we",    32'(SRAM_WE_n),     32'(1));
    checkOutput("rst_addr",  32'(SRAM_ADDR),     32'(0));
    checkOutput("rst_data",  32'(SRAM_DATA_OUT), 32'(0));
    checkOutput("rst_trig",  32'(Triggered),     32'(0));
    checkOutput("rst_taddr", 32'(Trig_Addr),     32'(0));
    checkOutput("rst_done",  32'(Capture_Done),  32'(0));
    nRESET = 1'b1;
    @(negedge CLK);
    $display("[TB] auto-trigger, Decimation=0, WIN_DATA=4");

    // Auto-trigger run: stores at 0..15 then 0, trigger at 12
    applyStimulus(1'b1, 24'd0, 1'b0, 1'b0, 4'd4, 8'h55, 8'hAA);
    for (int k = 0; k <= 16; k++) begin
      @(negedge CLK);
      checkOutput($sformatf("t1_we_%0d", k),   32'(SRAM_WE_n), 32'(0));
      checkOutput($sformatf("t1_addr_%0d", k), 32'(SRAM_ADDR), 32'(k % 16));
      if (k == 0) checkOutput("t1_data", 32'(SRAM_DATA_OUT), 32'(16'hAA55));
      if (k == 12) begin
        checkOutput("t1_taddr",     32'(Trig_Addr), 32'(12));
        checkOutput("t1_trig_late", 32'(Triggered), 32'(0));
      end
      if (k == 13) checkOutput("t1_trig", 32'(Triggered), 32'(1));
      if (k == 16) checkOutput("t1_notdone", 32'(Capture_Done), 32'(0));
    end
    @(negedge CLK);
    checkOutput("t1_end_we", 32'(SRAM_WE_n),    32'(1));
    checkOutput("t1_done",   32'(Capture_Done), 32'(1));
    @(negedge CLK);
    checkOutput("t1_hold_we", 32'(SRAM_WE_n), 32'(1));
    applyStimulus(1'b0, 24'd0, 1'b0, 1'b0, 4'd4, 8'h55, 8'hAA);
    @(negedge CLK);
    checkOutput("t1_stop_done", 32'(Capture_Done), 32'(0));
    checkOutput("t1_stop_trig", 32'(Triggered),    32'(1));

    // Decimation = 2: one strobe every third cycle
    applyStimulus(1'b1, 24'd2, 1'b1, 1'b0, 4'd4, 8'h80, 8'h00);
    for (int k = 0; k <= 8; k++) begin
      @(negedge CLK);
      checkOutput($sformatf("t2_we_%0d", k),   32'(SRAM_WE_n),
                  32'((k % 3 == 0) ? 1'b0 : 1'b1));
      checkOutput($sformatf("t2_addr_%0d", k), 32'(SRAM_ADDR), 32'(k / 3));
    end
    applyStimulus(1'b0, 24'd0, 1'b1, 1'b0, 4'd4, 8'h80, 8'h00);
    @(negedge CLK);

    // Ramp that never drops to Down: no trigger
    applyStimulus(1'b1, 24'd0, 1'b1, 1'b0, 4'd4, 8'h80, 8'h00);
    for (int k = 0; k <= 30; k++) begin
      @(negedge CLK);
      ADC_A = 8'(8'h80 + 4 * (k + 1));
    end
    checkOutput("t3_never_trig", 32'(Triggered), 32'(0));
    checkOutput("t3_running_we", 32'(SRAM_WE_n), 32'(0));
    applyStimulus(1'b0, 24'd0, 1'b1, 1'b0, 4'd4, 8'h00, 8'h00);
    @(negedge CLK);

    // Ramp from 0x00: fires on the store of exactly 0xC0 (store 24, addr 8)
    applyStimulus(1'b1, 24'd0, 1'b1, 1'b0, 4'd4, 8'h00, 8'h00);
    for (int k = 0; k <= 29; k++) begin
      @(negedge CLK);
      if (k == 23) checkOutput("t4_pre_trig", 32'(Triggered), 32'(0));
      if (k == 24) begin
        checkOutput("t4_taddr", 32'(Trig_Addr),     32'(8));
        checkOutput("t4_data",  32'(SRAM_DATA_OUT), 32'(16'h00C0));
      end
      if (k == 25) checkOutput("t4_trig", 32'(Triggered), 32'(1));
      if (k == 28) begin
        checkOutput("t4_last_we",   32'(SRAM_WE_n), 32'(0));
        checkOutput("t4_last_addr", 32'(SRAM_ADDR), 32'(12));
      end
      if (k == 29) begin
        checkOutput("t4_end_we", 32'(SRAM_WE_n),    32'(1));
        checkOutput("t4_done",   32'(Capture_Done), 32'(1));
      end
      ADC_A = (k + 1 < 12) ? 8'h00 : 8'(16 * (k + 1 - 12));
    end
    applyStimulus(1'b0, 24'd0, 1'b1, 1'b0, 4'd4, 8'h00, 8'h00);
    @(negedge CLK);

    // Trigger on ADC_B while ADC_A sits at 0xFF; fires at store 16 (addr 0)
    applyStimulus(1'b1, 24'd0, 1'b1, 1'b1, 4'd4, 8'hFF, 8'h00);
    for (int k = 0; k <= 18; k++) begin
      @(negedge CLK);
      if (k == 11) checkOutput("t5_pre_trig", 32'(Triggered), 32'(0));
      if (k == 16) checkOutput("t5_taddr", 32'(Trig_Addr), 32'(0));
      if (k == 17) checkOutput("t5_trig",  32'(Triggered), 32'(1));
      if (k == 18) begin
        checkOutput("t5_post_we",   32'(SRAM_WE_n), 32'(0));
        checkOutput("t5_post_addr", 32'(SRAM_ADDR), 32'(2));
      end
      ADC_B = (k + 1 < 12) ? 8'h00 : ((k + 1 < 16) ? 8'h50 : 8'hC0);
    end

    // Drop Start_Write_s during POSTTRIG, then restart
    Start_Write_s = 1'b0;
    @(negedge CLK);
    checkOutput("t6_stop_we",   32'(SRAM_WE_n),    32'(1));
    checkOutput("t6_stop_done", 32'(Capture_Done), 32'(0));
    applyStimulus(1'b1, 24'd0, 1'b0, 1'b0, 4'd4, 8'h12, 8'h34);
    @(negedge CLK);
    checkOutput("t6_restart_we",   32'(SRAM_WE_n), 32'(0));
    checkOutput("t6_restart_addr", 32'(SRAM_ADDR), 32'(0));
    checkOutput("t6_restart_trig", 32'(Triggered), 32'(0));
    @(negedge CLK);
    checkOutput("t6_run_addr", 32'(SRAM_ADDR), 32'(1));

    // Asynchronous reset mid-capture
    nRESET = 1'b0;
    #1;
    checkOutput("t7_we",   32'(SRAM_WE_n),     32'(1));
    checkOutput("t7_addr", 32'(SRAM_ADDR),     32'(0));
    checkOutput("t7_data", 32'(SRAM_DATA_OUT), 32'(0));
    Start_Write_s = 1'b0;
    @(negedge CLK);
    nRESET = 1'b1;
    @(negedge CLK);

    // WIN_DATA = 0: full-ring history, DONE right after the trigger store
    applyStimulus(1'b1, 24'd0, 1'b0, 1'b0, 4'd0, 8'h11, 8'h22);
    for (int k = 0; k <= 18; k++) begin
      @(negedge CLK);
      if (k == 15) checkOutput("t8_addr15", 32'(SRAM_ADDR), 32'(15));
      if (k == 16) begin
        checkOutput("t8_trig_we", 32'(SRAM_WE_n), 32'(0));
        checkOutput("t8_taddr",   32'(Trig_Addr), 32'(0));
        checkOutput("t8_trig0",   32'(Triggered), 32'(0));
      end
      if (k == 17) begin
        checkOutput("t8_end_we", 32'(SRAM_WE_n),    32'(1));
        checkOutput("t8_done",   32'(Capture_Done), 32'(1));
        checkOutput("t8_trig",   32'(Triggered),    32'(1));
      end
      if (k == 18) checkOutput("t8_hold_we", 32'(SRAM_WE_n), 32'(1));
    end
    applyStimulus(1'b0, 24'd0, 1'b0, 1'b0, 4'd4, 8'h00, 8'h00);
    @(negedge CLK);

`ifdef CAPTURE_SLOPE_EN
    // Falling slope: arm at >= UP, fire on the first store <= Down (addr 7)
    Trig_Slope = 1'b1;
    applyStimulus(1'b1, 24'd0, 1'b1, 1'b0, 4'd4, 8'hFF, 8'h00);
    for (int k = 0; k <= 24; k++) begin
      @(negedge CLK);
      if (k == 22) checkOutput("t9_pre_trig", 32'(Triggered), 32'(0));
      if (k == 23) checkOutput("t9_taddr", 32'(Trig_Addr), 32'(7));
      if (k == 24) checkOutput("t9_trig",  32'(Triggered), 32'(1));
      ADC_A = (k + 1 < 12) ? 8'hFF : 8'(8'hF0 - 16 * (k + 1 - 12));
    end
    Trig_Slope = 1'b0;
    applyStimulus(1'b0, 24'd0, 1'b0, 1'b0, 4'd4, 8'h00, 8'h00);
    @(negedge CLK);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
